// File: rtl/nfu2_seq.sv
// Accumulation sequencer for the NFU-2 stage: streams K packed groups through an
// external combinational adder tree and sums the tree outputs into one result.
module nfu2_seq #(
  parameter int unsigned N     = 16,
  parameter int unsigned Tn    = 16,
  parameter int unsigned NxTn  = 256,
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [CNT_W-1:0] i_num_groups,
  input  logic [NxTn-1:0] i_vals,
  input  logic            i_vals_valid,
  output logic            o_vals_ready,
  output logic [NxTn-1:0] o_tree_vals,
  input  logic [N-1:0]    i_tree_sum,
  output logic [N-1:0]    o_res,
  output logic            o_res_valid,
  input  logic            i_res_ready,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] k_reg;
  logic [CNT_W-1:0] count;
  logic [N-1:0]     acc;
  logic             stage_valid;

  logic             accept;
  logic [CNT_W-1:0] count_inc;
  logic [N-1:0]     acc_sum;

  assign accept    = i_vals_valid & o_vals_ready;
  assign count_inc = count + CNT_W'(1);
  // Unsigned modulo-2^N accumulation; wrap is intentional.
  assign acc_sum   = acc + i_tree_sum;

  // The tree operand register is the pipeline stage; stage_valid marks that
  // i_tree_sum this cycle belongs to a freshly accepted group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k_reg        <= '0;
      count        <= '0;
      acc          <= '0;
      stage_valid  <= 1'b0;
      o_tree_vals  <= '0;
      o_res        <= '0;
      o_res_valid  <= 1'b0;
      o_vals_ready <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      stage_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            k_reg  <= i_num_groups;
            count  <= '0;
            acc    <= '0;
            o_busy <= 1'b1;
            if (i_num_groups == '0) begin
              state        <= OUT;
              o_res        <= '0;
              o_res_valid  <= 1'b1;
              o_vals_ready <= 1'b0;
            end else begin
              state        <= ACCUM;
              o_vals_ready <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (accept) begin
            for (int unsigned j = 0; j < Tn; j++) begin
              o_tree_vals[N*j +: N] <= i_vals[N*j +: N];
            end
            stage_valid  <= 1'b1;
            count        <= count_inc;
            o_vals_ready <= (count_inc < k_reg);
          end
          if (stage_valid) begin
            acc <= acc_sum;
            // Final group's sum is in flight: publish it directly.
            if (count == k_reg) begin
              state       <= OUT;
              o_res       <= acc_sum;
              o_res_valid <= 1'b1;
            end
          end
        end

        OUT: begin
          if (i_res_ready) begin
            state       <= IDLE;
            o_res_valid <= 1'b0;
            o_busy      <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          o_res_valid  <= 1'b0;
          o_vals_ready <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nfu2_seq.sv
// Directed bench for nfu2_seq with a behavioural model of the external adder tree.
module tb_nfu2_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  num_groups;
  logic [255:0] vals;
  logic         vals_valid;
  logic         vals_ready;
  logic [255:0] tree_vals;
  logic [15:0]  tree_sum;
  logic [15:0]  res;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int accepts  = 0;
  int results  = 0;
  int base_acc;
  int base_res;

  always #5 clk = ~clk;

  nfu2_seq #(.N(16), .Tn(16), .NxTn(256), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_num_groups (num_groups),
    .i_vals       (vals),
    .i_vals_valid (vals_valid),
    .o_vals_ready (vals_ready),
    .o_tree_vals  (tree_vals),
    .i_tree_sum   (tree_sum),
    .o_res        (res),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_busy       (busy)
  );

  // External n2 adder tree: 16-lane modular sum.
  always_comb begin
    tree_sum = '0;
    for (int j = 0; j < 16; j++) tree_sum = tree_sum + tree_vals[16*j +: 16];
  end

  always @(posedge clk) begin
    if (!rst && vals_valid && vals_ready) accepts++;
    if (!rst && res_valid && res_ready) results++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    chk(tag, 256'(res_valid), 256'(1));
  endtask

  function automatic logic [255:0] all_lanes(input logic [15:0] v);
    return {16{v}};
  endfunction

  function automatic logic [255:0] lane0(input logic [15:0] v);
    return {240'b0, v};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; num_groups = '0; vals = '0;
    vals_valid = 1'b0; res_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", 256'(vals_ready), 256'(0));
    chk("rst_res_valid", 256'(res_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_res", 256'(res), 256'(0));
    chk("rst_tree", tree_vals, 256'(0));

    // K=3, all lanes 1, back-to-back
    base_acc = accepts;
    start = 1'b1; num_groups = 16'd3;
    step();
    start = 1'b0;
    chk("k3_ready", 256'(vals_ready), 256'(1));
    chk("k3_busy", 256'(busy), 256'(1));
    vals = all_lanes(16'd1); vals_valid = 1'b1;
    step(); step(); step();
    vals_valid = 1'b0;
    chk("k3_ready_done", 256'(vals_ready), 256'(0));
    chk("k3_not_yet", 256'(res_valid), 256'(0));
    step();
    chk("k3_valid", 256'(res_valid), 256'(1));
    chk("k3_res", 256'(res), 256'(16'h0030));
    step();
    chk("k3_valid_drop", 256'(res_valid), 256'(0));
    chk("k3_idle", 256'(busy), 256'(0));
    chk("k3_accepts", 256'(accepts - base_acc), 256'(3));

    // K=0
    base_acc = accepts;
    start = 1'b1; num_groups = 16'd0;
    step();
    start = 1'b0;
    chk("k0_ready", 256'(vals_ready), 256'(0));
    chk("k0_valid", 256'(res_valid), 256'(1));
    chk("k0_res", 256'(res), 256'(0));
    step();
    chk("k0_idle", 256'(busy), 256'(0));
    chk("k0_accepts", 256'(accepts - base_acc), 256'(0));

    // K=2 wrap: 0x8000 + 0x8001
    start = 1'b1; num_groups = 16'd2;
    step();
    start = 1'b0;
    vals = lane0(16'h8000); vals_valid = 1'b1;
    step();
    vals = lane0(16'h8001);
    step();
    vals_valid = 1'b0;
    wait_res("wrap_wait");
    chk("wrap_res", 256'(res), 256'(16'h0001));
    step();

    // K=4 with gaps, K changed mid-job, stalled output, valid while not ready
    base_acc = accepts;
    res_ready = 1'b0;
    start = 1'b1; num_groups = 16'd4;
    step();
    start = 1'b0; num_groups = 16'd7;
    for (int g = 0; g < 4; g++) begin
      case (g)
        0: vals = lane0(16'h1234);
        1: vals = lane0(16'h0F0F);
        2: vals = lane0(16'h2222);
        default: vals = lane0(16'h0001);
      endcase
      vals_valid = 1'b1;
      step();
      vals = all_lanes(16'hFFFF);
      vals_valid = (g == 3);
      step(); step();
    end
    wait_res("gap_wait");
    for (int s = 0; s < 5; s++) begin
      chk("gap_stall_valid", 256'(res_valid), 256'(1));
      chk("gap_stall_res", 256'(res), 256'(16'h4366));
      step();
    end
    vals_valid = 1'b0;
    res_ready = 1'b1;
    chk("gap_res_final", 256'(res), 256'(16'h4366));
    step();
    chk("gap_done", 256'(res_valid), 256'(0));
    chk("gap_accepts", 256'(accepts - base_acc), 256'(4));

    // K=5 aborted by reset after 2 accepts, then clean K=1 job
    start = 1'b1; num_groups = 16'd5;
    step();
    start = 1'b0;
    vals = all_lanes(16'd3); vals_valid = 1'b1;
    step(); step();
    vals_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", 256'(vals_ready), 256'(0));
    chk("abort_valid", 256'(res_valid), 256'(0));
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_res", 256'(res), 256'(0));
    chk("abort_tree", tree_vals, 256'(0));
    step();
    chk("abort_quiet", 256'(res_valid), 256'(0));
    start = 1'b1; num_groups = 16'd1;
    step();
    start = 1'b0;
    vals = all_lanes(16'd2); vals_valid = 1'b1;
    step();
    vals_valid = 1'b0;
    wait_res("fresh_wait");
    chk("fresh_res", 256'(res), 256'(16'd32));
    step();
    chk("fresh_idle", 256'(busy), 256'(0));

    // K=2 with start pulses in ACCUM, OUT and on the output handshake
    base_res = results;
    res_ready = 1'b0;
    start = 1'b1; num_groups = 16'd2;
    step();
    start = 1'b0;
    vals = all_lanes(16'd1); vals_valid = 1'b1;
    step();
    start = 1'b1; num_groups = 16'd9;
    step();
    start = 1'b0; vals_valid = 1'b0;
    wait_res("ign_wait");
    chk("ign_res", 256'(res), 256'(16'd32));
    start = 1'b1;
    step();
    chk("ign_out_valid", 256'(res_valid), 256'(1));
    chk("ign_out_res", 256'(res), 256'(16'd32));
    res_ready = 1'b1;
    step();
    start = 1'b0;
    chk("ign_idle_busy", 256'(busy), 256'(0));
    chk("ign_idle_valid", 256'(res_valid), 256'(0));
    step(); step();
    chk("ign_still_idle", 256'(busy), 256'(0));
    chk("ign_one_result", 256'(results - base_res), 256'(1));

    // Reset wins over start in the same cycle
    rst = 1'b1; start = 1'b1; num_groups = 16'd3;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", 256'(busy), 256'(0));
    chk("rst_prio_ready", 256'(vals_ready), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
